// File: rtl/dec_1.sv
// dec_1: fully connected decoder layer, y = W^T z + b, signed fixed point (BITSIZE bits, FRAC fractional).
// Ports: clk, reset (async, active-high), start (one-cycle request, sampled in IDLE), z (6 latent words),
//        w (6x10 weights, row-major by latent index), b (10 biases), busy, done (1-cycle pulse), y (10 results).
// Latency 7 cycles from start sample to done; start while busy is dropped, not queued.
// Define DEC_1_SAT_EN to clamp mul/add results to the signed range; otherwise results wrap.
module dec_1 #(
  parameter int BITSIZE = 20,
  parameter int FRAC    = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BITSIZE*6-1:0]    z,
  input  logic [BITSIZE*10*6-1:0] w,
  input  logic [BITSIZE*10-1:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [BITSIZE*10-1:0]   y
);

  localparam int N_IN  = 6;
  localparam int N_OUT = 10;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                     state;
  logic [2:0]                 k;
  logic signed [BITSIZE-1:0]  zreg [N_IN];
  logic signed [BITSIZE-1:0]  acc  [N_OUT];

`ifdef DEC_1_SAT_EN
  // Signed range bounds, sign-extended to the product width for comparison.
  localparam logic signed [2*BITSIZE-1:0] P_MAX = {{(BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [2*BITSIZE-1:0] P_MIN = {{(BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};
  localparam logic signed [BITSIZE-1:0]   W_MAX = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic signed [BITSIZE-1:0]   W_MIN = {1'b1, {(BITSIZE-1){1'b0}}};
`endif

  // Full-width signed product, floor-shifted by FRAC, reduced to BITSIZE bits.
  function automatic logic signed [BITSIZE-1:0] mul_q(
    input logic signed [BITSIZE-1:0] a,
    input logic signed [BITSIZE-1:0] c
  );
    logic signed [2*BITSIZE-1:0] p;
    p = a * c;
    p = p >>> FRAC;
`ifdef DEC_1_SAT_EN
    if (p > P_MAX)      mul_q = W_MAX;
    else if (p < P_MIN) mul_q = W_MIN;
    else                mul_q = BITSIZE'(p);
`else
    mul_q = BITSIZE'(p);
`endif
  endfunction

  // BITSIZE+1-bit sum reduced to BITSIZE bits; overflow shows as the top two bits disagreeing.
  function automatic logic signed [BITSIZE-1:0] add_q(
    input logic signed [BITSIZE-1:0] a,
    input logic signed [BITSIZE-1:0] c
  );
    logic signed [BITSIZE:0] s;
    s = {a[BITSIZE-1], a} + {c[BITSIZE-1], c};
`ifdef DEC_1_SAT_EN
    if (s[BITSIZE] != s[BITSIZE-1]) add_q = s[BITSIZE] ? W_MIN : W_MAX;
    else                            add_q = s[BITSIZE-1:0];
`else
    add_q = BITSIZE'(s);
`endif
  endfunction

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      k     <= '0;
      done  <= 1'b0;
      y     <= '0;
      for (int j = 0; j < N_IN; j++)  zreg[j] <= '0;
      for (int i = 0; i < N_OUT; i++) acc[i]  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int j = 0; j < N_IN; j++)  zreg[j] <= z[BITSIZE*j +: BITSIZE];
            for (int i = 0; i < N_OUT; i++) acc[i]  <= b[BITSIZE*i +: BITSIZE];
            k     <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          // All lanes consume the same latent element; weight row k is shared across lanes.
          for (int i = 0; i < N_OUT; i++)
            acc[i] <= add_q(acc[i],
                            mul_q(zreg[k], w[BITSIZE*(N_OUT*int'(k) + i) +: BITSIZE]));
          k <= k + 3'd1;
          if (k == 3'd5) state <= S_OUT;
        end
        S_OUT: begin
          for (int i = 0; i < N_OUT; i++) y[BITSIZE*i +: BITSIZE] <= acc[i];
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_1.sv
// Directed testbench for dec_1: reset values, accumulation, lane/row mapping, floor shift,
// overflow behaviour, start-while-busy rejection and mid-run reset abort.
module tb_dec_1;
  localparam int BS = 20;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [BS*6-1:0]      z;
  logic [BS*10*6-1:0]   w;
  logic [BS*10-1:0]     b;
  logic                 busy, done;
  logic [BS*10-1:0]     y;

  logic [BS-1:0] zv [6];
  logic [BS-1:0] wv [6][10];
  logic [BS-1:0] bv [10];

  int total = 0;
  int bad   = 0;

  dec_1 #(.BITSIZE(BS), .FRAC(12)) dut (
    .clk(clk), .reset(reset), .start(start), .z(z), .w(w), .b(b),
    .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  always_comb begin
    z = '0;
    w = '0;
    b = '0;
    for (int k = 0; k < 6; k++) begin
      z[BS*k +: BS] = zv[k];
      for (int i = 0; i < 10; i++) w[BS*10*k + BS*i +: BS] = wv[k][i];
    end
    for (int i = 0; i < 10; i++) b[BS*i +: BS] = bv[i];
  end

  task automatic set_all(input logic [BS-1:0] zval, input logic [BS-1:0] wval,
                         input logic [BS-1:0] bval);
    for (int k = 0; k < 6; k++) begin
      zv[k] = zval;
      for (int i = 0; i < 10; i++) wv[k][i] = wval;
    end
    for (int i = 0; i < 10; i++) bv[i] = bval;
  endtask

  // Pulses start for one edge, then watches from the cycle after the start sample.
  // lat = index of the cycle (0 = cycle after start sample) where done is seen, -1 on timeout.
  task automatic run_op(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset;
    set_all('0, '0, '0);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ctrl: got busy=%b done=%b want 0 0", busy, done);
    end
    total++;
    if (y !== '0) begin
      bad++;
      $display("FAIL reset_y: got %h want 0", y);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bcnt;
    set_all(20'h01000, 20'h00800, 20'h0);
    run_op(lat, bcnt);
    check_val("basic_latency", lat, 7);
    // Six MAC cycles plus the OUT cycle; the done cycle is already IDLE.
    check_val("basic_busy_cycles", bcnt, 7);
    for (int i = 0; i < 10; i++) check_val($sformatf("basic_y%0d", i), y[BS*i +: BS], 20'h03000);
    @(negedge clk);
    check_val("basic_done_pulse", done, 0);
    check_val("basic_y_hold", y[0 +: BS], 20'h03000);
  endtask

  task automatic test_mapping;
    int lat, bcnt;
    set_all('0, 20'h00800, '0);
    for (int i = 0; i < 10; i++) bv[i] = BS'(i) << 12;
    run_op(lat, bcnt);
    check_val("bias_latency", lat, 7);
    for (int i = 0; i < 10; i++) check_val($sformatf("bias_y%0d", i), y[BS*i +: BS], BS'(i) << 12);
    set_all('0, '0, '0);
    zv[2] = 20'h01000;
    wv[2][7] = 20'hFE000;
    run_op(lat, bcnt);
    check_val("map_latency", lat, 7);
    for (int i = 0; i < 10; i++)
      check_val($sformatf("map_y%0d", i), y[BS*i +: BS], (i == 7) ? 20'hFE000 : 20'h0);
  endtask

  task automatic test_floor;
    int lat, bcnt;
    set_all('0, '0, '0);
    zv[0] = 20'hFFFFF;
    wv[0][0] = 20'h00800;
    run_op(lat, bcnt);
    check_val("floor_latency", lat, 7);
    check_val("floor_y0", y[0 +: BS], 20'hFFFFF);
    check_val("floor_y1", y[BS +: BS], 20'h0);
  endtask

  task automatic test_overflow;
    int lat, bcnt;
    logic [BS-1:0] exp_y0;
`ifdef DEC_1_SAT_EN
    exp_y0 = 20'h7FFFF;
`else
    exp_y0 = 20'hC8000;
`endif
    set_all('0, '0, '0);
    zv[0] = 20'h64000;
    wv[0][0] = 20'h02000;
    run_op(lat, bcnt);
    check_val("ovf_latency", lat, 7);
    check_val("ovf_y0", y[0 +: BS], exp_y0);
  endtask

  task automatic test_start_busy;
    int dones, first;
    logic [BS*10-1:0] y_seen;
    dones = 0;
    first = -1;
    y_seen = '0;
    set_all(20'h01000, 20'h00800, 20'h0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    // z is captured at start, so clearing it now must not change the result.
    for (int k = 0; k < 6; k++) zv[k] = '0;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) start = 1'b1;
      if (c == 3) start = 1'b0;
      if (done) begin
        dones++;
        if (first < 0) begin
          first = c;
          y_seen = y;
        end
      end
    end
    check_val("busy_start_dones", dones, 1);
    check_val("busy_start_latency", first, 7);
    for (int i = 0; i < 10; i++)
      check_val($sformatf("busy_start_y%0d", i), y_seen[BS*i +: BS], 20'h03000);
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, dones;
    dones = 0;
    set_all(20'h01000, 20'h00800, 20'h0);
    for (int i = 0; i < 10; i++) bv[i] = 20'h00100;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("pre_abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    total++;
    if (y !== '0) begin
      bad++;
      $display("FAIL abort_y: got %h want 0", y);
    end
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_val("abort_no_done", dones, 0);
    set_all(20'h01000, 20'h00800, 20'h0);
    run_op(lat, bcnt);
    check_val("restart_latency", lat, 7);
    for (int i = 0; i < 10; i++)
      check_val($sformatf("restart_y%0d", i), y[BS*i +: BS], 20'h03000);
  endtask

  initial begin
    set_all('0, '0, '0);
    test_reset();
    test_basic();
    test_mapping();
    test_floor();
    test_overflow();
    test_start_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
